// File: rtl/branch_predict_resolve_pkg.sv
// Shared opcode/rt encodings and BHT counter helpers for the branch predict/resolve unit.
package branch_predict_resolve_pkg;

   localparam logic [5:0] EXE_REGIMM_INST = 6'b000001;
   localparam logic [5:0] EXE_BEQ         = 6'b000100;
   localparam logic [5:0] EXE_BNE         = 6'b000101;
   localparam logic [5:0] EXE_BLEZ        = 6'b000110;
   localparam logic [5:0] EXE_BGTZ        = 6'b000111;

   localparam logic [4:0] EXE_BLTZ   = 5'b00000;
   localparam logic [4:0] EXE_BGEZ   = 5'b00001;
   localparam logic [4:0] EXE_BLTZAL = 5'b10000;
   localparam logic [4:0] EXE_BGEZAL = 5'b10001;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} bht_cnt_e;

   // Two-bit saturating counter step toward the resolved direction.
   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      nxt = cnt;
      if (taken && cnt != ST)       nxt = cnt + 2'd1;
      else if (!taken && cnt != SNT) nxt = cnt - 2'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/branch_predict_resolve_branch_cond.sv
// ID-stage branch condition evaluator: decodes conditional branches and resolves them.
module branch_cond
   import branch_predict_resolve_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [5:0]       op_i,
   input  logic [4:0]       rt_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             is_branch_o,
   output logic             taken_o
);

   logic sign_a;
   logic a_zero;

   assign sign_a = a_i[WIDTH-1];
   assign a_zero = (a_i == WIDTH'(ZeroWord));

   always_comb begin
      is_branch_o = 1'b0;
      taken_o     = 1'b0;
      case (op_i)
         EXE_BEQ:  begin is_branch_o = 1'b1; taken_o = (a_i == b_i);       end
         EXE_BNE:  begin is_branch_o = 1'b1; taken_o = (a_i != b_i);       end
         EXE_BGTZ: begin is_branch_o = 1'b1; taken_o = !sign_a && !a_zero; end
         EXE_BLEZ: begin is_branch_o = 1'b1; taken_o = sign_a || a_zero;   end
         EXE_REGIMM_INST: begin
            case (rt_i)
               EXE_BGEZ, EXE_BGEZAL: begin is_branch_o = 1'b1; taken_o = !sign_a; end
               EXE_BLTZ, EXE_BLTZAL: begin is_branch_o = 1'b1; taken_o = sign_a;  end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/branch_predict_resolve.sv
// Bimodal BHT predictor read in IF, resolved in ID; flags mispredicts, trains, counts.
module branch_predict_resolve
   import branch_predict_resolve_pkg::*;
#(
   parameter int         WIDTH    = 32,
   parameter int         IDX_BITS = 6,
   parameter logic [1:0] CNT_INIT = 2'b01
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      pc_f,
   output logic             pred_taken_f,
   input  logic             stall_d,
   input  logic             flush_d,
   input  logic             valid_d,
   input  logic [5:0]       op_d,
   input  logic [4:0]       rt_d,
   input  logic [WIDTH-1:0] cin_a,
   input  logic [WIDTH-1:0] cin_b,
   output logic             is_branch_d,
   output logic             taken_d,
   output logic             pred_taken_d,
   output logic             mispredict_d,
   output logic [31:0]      branch_cnt,
   output logic [31:0]      mispredict_cnt
);

   localparam int DEPTH = 1 << IDX_BITS;

   logic [DEPTH-1:0][1:0] bht_q, bht_d;
   logic [IDX_BITS-1:0]   idx_f;
   logic [IDX_BITS-1:0]   idx_q, idx_d;
   logic                  pred_q, pred_d;
   logic [31:0]           branch_cnt_q, branch_cnt_d;
   logic [31:0]           mispredict_cnt_q, mispredict_cnt_d;
   logic                  resolve;
   logic                  unused_pc_bits;

   assign idx_f          = pc_f[IDX_BITS+1:2];
   assign unused_pc_bits = ^{pc_f[31:IDX_BITS+2], pc_f[1:0]};
   // Plain table read: a write to the same entry this cycle is seen next cycle.
   assign pred_taken_f   = bht_q[idx_f][1];

   branch_cond #(.WIDTH(WIDTH)) u_cond (
      .op_i        (op_d),
      .rt_i        (rt_d),
      .a_i         (cin_a),
      .b_i         (cin_b),
      .is_branch_o (is_branch_d),
      .taken_o     (taken_d)
   );

   assign pred_taken_d = pred_q;
   assign mispredict_d = valid_d & is_branch_d & !stall_d & (taken_d != pred_q);
   assign resolve      = valid_d & is_branch_d & !stall_d & !flush_d;

   always_comb begin
      pred_d = pred_q;
      idx_d  = idx_q;
      if (flush_d) begin
         pred_d = 1'b0;
         idx_d  = '0;
      end else if (!stall_d) begin
         pred_d = pred_taken_f;
         idx_d  = idx_f;
      end
   end

   always_comb begin
      bht_d            = bht_q;
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (resolve) begin
         bht_d[idx_q] = sat_update(bht_q[idx_q], taken_d);
         branch_cnt_d = branch_cnt_q + 32'd1;
         if (taken_d != pred_q) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bht_q            <= {DEPTH{CNT_INIT}};
         pred_q           <= 1'b0;
         idx_q            <= '0;
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         bht_q            <= bht_d;
         pred_q           <= pred_d;
         idx_q            <= idx_d;
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_branch_predict_resolve;
   import branch_predict_resolve_pkg::*;

   localparam logic [5:0]  OP_ADDI = 6'b001000;
   localparam logic [31:0] PC_A    = 32'h0040_0010; // idx 4
   localparam logic [31:0] PC_B    = 32'h0040_0020; // idx 8

   logic        clk = 1'b0;
   logic        rst, stall_d, flush_d, valid_d;
   logic [31:0] pc_f, cin_a, cin_b;
   logic [5:0]  op_d;
   logic [4:0]  rt_d;
   logic        pred_taken_f, is_branch_d, taken_d, pred_taken_d, mispredict_d;
   logic [31:0] branch_cnt, mispredict_cnt;

   typedef enum int {S_PF, S_BR, S_TK, S_PD, S_MP, S_BC, S_MC, S_BHT} sel_e;
   typedef struct {
      sel_e        sel;
      int          idx;
      logic [31:0] val;
      string       name;
   } chk_t;

   chk_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   bit   done  = 1'b0;

   branch_predict_resolve #(.WIDTH(32), .IDX_BITS(6), .CNT_INIT(2'b01)) dut (
      .clk(clk), .rst(rst), .pc_f(pc_f), .pred_taken_f(pred_taken_f),
      .stall_d(stall_d), .flush_d(flush_d), .valid_d(valid_d), .op_d(op_d), .rt_d(rt_d),
      .cin_a(cin_a), .cin_b(cin_b), .is_branch_d(is_branch_d), .taken_d(taken_d),
      .pred_taken_d(pred_taken_d), .mispredict_d(mispredict_d),
      .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
   );

   always #5 clk = ~clk;

   task automatic expect_v(input sel_e s, input logic [31:0] v, input string nm, input int idx = 0);
      chk_t c;
      c.sel = s; c.idx = idx; c.val = v; c.name = nm;
      q.push_back(c);
   endtask

   task automatic drive(input logic [31:0] pc, input logic v, input logic [5:0] op, input logic [4:0] rt,
                        input logic [31:0] a, input logic [31:0] b, input logic st, input logic fl);
      pc_f = pc; valid_d = v; op_d = op; rt_d = rt; cin_a = a; cin_b = b; stall_d = st; flush_d = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops every expectation queued for this cycle and compares at the falling edge.
   initial begin
      chk_t        c;
      logic [31:0] act;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            c = q.pop_front();
            case (c.sel)
               S_PF:    act = {31'd0, pred_taken_f};
               S_BR:    act = {31'd0, is_branch_d};
               S_TK:    act = {31'd0, taken_d};
               S_PD:    act = {31'd0, pred_taken_d};
               S_MP:    act = {31'd0, mispredict_d};
               S_BC:    act = branch_cnt;
               S_MC:    act = mispredict_cnt;
               default: act = {30'd0, dut.bht_q[c.idx]};
            endcase
            n_vec++;
            if (act !== c.val) begin
               n_bad++;
               $display("FAIL %s: got %h expected %h", c.name, act, c.val);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      drive(32'h0, 1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      tick(); tick();
      rst = 1'b0;

      // C0: reset state
      drive(PC_A, 1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      expect_v(S_PF, 0, "rst_pred_f");
      expect_v(S_PD, 0, "rst_pred_d");
      expect_v(S_BC, 0, "rst_bcnt");
      expect_v(S_MC, 0, "rst_mcnt");
      expect_v(S_BHT, 1, "rst_bht4", 4);
      tick();
      // C1: first BEQ taken, predicted not-taken
      drive(PC_A, 1'b1, EXE_BEQ, 5'd0, 32'd5, 32'd5, 1'b0, 1'b0);
      expect_v(S_BR, 1, "beq_isbr");
      expect_v(S_TK, 1, "beq_taken");
      expect_v(S_PD, 0, "beq1_pred_d");
      expect_v(S_MP, 1, "beq1_misp");
      tick();
      // C2
      expect_v(S_BHT, 2, "bht4_wt", 4);
      expect_v(S_BC, 1, "bcnt1");
      expect_v(S_MC, 1, "mcnt1");
      expect_v(S_MP, 1, "beq2_misp");
      tick();
      // C3
      expect_v(S_PD, 1, "beq3_pred_d");
      expect_v(S_MP, 0, "beq3_misp");
      expect_v(S_BHT, 3, "bht4_st", 4);
      expect_v(S_MC, 2, "mcnt2");
      tick();
      // C4
      expect_v(S_BHT, 3, "bht4_sat", 4);
      expect_v(S_BC, 3, "bcnt3");
      tick();
      // C5: BNE equal operands -> not taken against strong-taken prediction
      drive(PC_A, 1'b1, EXE_BNE, 5'd0, 32'd7, 32'd7, 1'b0, 1'b0);
      expect_v(S_PF, 1, "pred_f_taken");
      expect_v(S_PD, 1, "bne_pred_d");
      expect_v(S_TK, 0, "bne_taken");
      expect_v(S_MP, 1, "bne_misp");
      expect_v(S_BC, 4, "bcnt4");
      tick();
      // C6..C10: condition evaluation, valid low so nothing trains
      drive(PC_A, 1'b0, EXE_BGTZ, 5'd0, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
      expect_v(S_BHT, 2, "bht4_after_bne", 4);
      expect_v(S_BC, 5, "bcnt5");
      expect_v(S_MC, 3, "mcnt3");
      expect_v(S_TK, 0, "bgtz_neg");
      tick();
      drive(PC_A, 1'b0, EXE_BLEZ, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      expect_v(S_TK, 1, "blez_zero");
      tick();
      drive(PC_A, 1'b0, EXE_REGIMM_INST, EXE_BGEZAL, 32'd0, 32'd0, 1'b0, 1'b0);
      expect_v(S_BR, 1, "bgezal_isbr");
      expect_v(S_TK, 1, "bgezal_zero");
      tick();
      drive(PC_A, 1'b0, EXE_REGIMM_INST, EXE_BLTZ, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
      expect_v(S_TK, 1, "bltz_neg");
      tick();
      drive(PC_A, 1'b1, OP_ADDI, 5'd0, 32'd3, 32'd3, 1'b0, 1'b0);
      expect_v(S_BR, 0, "addi_isbr");
      expect_v(S_TK, 0, "addi_taken");
      expect_v(S_MP, 0, "addi_misp");
      tick();
      // C11: load idx 8 into ID; check ADDI did not count
      drive(PC_B, 1'b0, EXE_BGTZ, 5'd0, 32'd1, 32'd0, 1'b0, 1'b0);
      expect_v(S_BC, 5, "addi_bcnt");
      expect_v(S_MC, 3, "addi_mcnt");
      expect_v(S_TK, 1, "bgtz_pos");
      tick();
      // C12..C14: stalled branch on idx 8
      for (int i = 0; i < 3; i++) begin
         drive(PC_A, 1'b1, EXE_BEQ, 5'd0, 32'd1, 32'd1, 1'b1, 1'b0);
         expect_v(S_PD, 0, "stall_pred_d");
         expect_v(S_MP, 0, "stall_misp");
         expect_v(S_BHT, 1, "stall_bht8", 8);
         expect_v(S_BC, 5, "stall_bcnt");
         tick();
      end
      // C15: release
      drive(PC_A, 1'b1, EXE_BEQ, 5'd0, 32'd1, 32'd1, 1'b0, 1'b0);
      expect_v(S_PD, 0, "rel_pred_d");
      expect_v(S_MP, 1, "rel_misp");
      tick();
      // C16: flush + stall with a valid branch
      drive(PC_A, 1'b1, EXE_BEQ, 5'd0, 32'd1, 32'd1, 1'b1, 1'b1);
      expect_v(S_BHT, 2, "rel_bht8", 8);
      expect_v(S_BC, 6, "rel_bcnt");
      expect_v(S_MC, 4, "rel_mcnt");
      expect_v(S_PD, 1, "preflush_pred_d");
      tick();
      // C17: register cleared, no training; preset mispredict counter for wrap
      drive(PC_A, 1'b1, EXE_BEQ, 5'd0, 32'd1, 32'd1, 1'b0, 1'b0);
      expect_v(S_PD, 0, "flush_pred_d");
      expect_v(S_BHT, 2, "flush_bht4", 4);
      expect_v(S_BC, 6, "flush_bcnt");
      expect_v(S_MP, 1, "wrap_misp");
      force dut.mispredict_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.mispredict_cnt_q;
      tick();
      // C18: wrap observed; assert reset mid-run with a live branch
      rst = 1'b1;
      drive(PC_A, 1'b1, EXE_BEQ, 5'd0, 32'd1, 32'd1, 1'b0, 1'b0);
      expect_v(S_MC, 0, "mcnt_wrap");
      expect_v(S_BC, 7, "wrap_bcnt");
      expect_v(S_BHT, 2, "wrap_bht0", 0);
      tick();
      // C19: post-reset state
      rst = 1'b0;
      drive(PC_A, 1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      expect_v(S_BHT, 1, "rst2_bht4", 4);
      expect_v(S_BHT, 1, "rst2_bht8", 8);
      expect_v(S_BHT, 1, "rst2_bht0", 0);
      expect_v(S_BC, 0, "rst2_bcnt");
      expect_v(S_MC, 0, "rst2_mcnt");
      expect_v(S_PD, 0, "rst2_pred_d");
      expect_v(S_PF, 0, "rst2_pred_f");
      tick();

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      done = 1'b1;
      $finish;
   end

   initial begin
      #5000;
      if (!done) begin
         $display("FAIL timeout: got no finish expected finish");
         $fatal(1, "timeout");
      end
   end

endmodule
